regfile_xfer: RTL and testbench

Sequenced transfer engine that acts as the initiator on the register-file read/write ports: on command it walks R0..R7, either dumping each register to memory or loading each register from memory. It sits between the datapath's register file and the memory interface and is used for context save/restore and debug snapshot. Every transfer is one register per memory handshake, in ascending register order.

---
 rtl/regfile_xfer_if.sv | 41 ++++
 rtl/regfile_xfer.sv | 114 +++++++++++
 tb/tb_regfile_xfer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_xfer_if.sv
// rtl/regfile_xfer_if.sv - command, register-file and memory signals of regfile_xfer
// REGXFER_CHECKSUM_EN adds the checksum signal.
interface regfile_xfer_if;
  logic        start;
  logic        dir;
  logic [15:0] base_addr;
  logic        busy;
  logic        done;
  logic [2:0]  rf_readAdd;
  logic [15:0] rf_out;
  logic        rf_write;
  logic [2:0]  rf_writeAdd;
  logic [15:0] rf_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
`ifdef REGXFER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  modport master (
    input  start, dir, base_addr, rf_out, mem_rdata, mem_ack,
    output busy, done, rf_readAdd, rf_write, rf_writeAdd, rf_in,
           mem_req, mem_we, mem_addr, mem_wdata
`ifdef REGXFER_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output start, dir, base_addr, rf_out, mem_rdata, mem_ack,
    input  busy, done, rf_readAdd, rf_write, rf_writeAdd, rf_in,
           mem_req, mem_we, mem_addr, mem_wdata
`ifdef REGXFER_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/regfile_xfer.sv
// rtl/regfile_xfer.sv - walks R0..R(NREGS-1), dumping to or loading from memory
// REGXFER_CHECKSUM_EN adds a running 16-bit sum of transferred words.
module regfile_xfer #(
  parameter int NREGS  = 8,
  parameter int STRIDE = 2
) (
  input  logic          clk,
  input  logic          reset,
  regfile_xfer_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        dir_q;
  logic [15:0] base_q;
  logic [15:0] rf_in_q;
  logic [2:0]  wadd_q;
  logic [15:0] addr_cur;
  logic        last;
  logic        accept;

  assign last     = (idx == 3'(NREGS - 1));
  assign accept   = (state == IDLE) && bus.start;
  assign addr_cur = base_q + 16'(STRIDE) * {13'd0, idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= 3'd0;
      dir_q   <= 1'b0;
      base_q  <= 16'd0;
      rf_in_q <= 16'd0;
      wadd_q  <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (accept) begin
        dir_q  <= bus.dir;
        base_q <= bus.base_addr;
      end
      if (state == REQ && bus.mem_ack && dir_q) begin
        rf_in_q <= bus.mem_rdata;
        wadd_q  <= idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = REQ;
          idx_nxt   = 3'd0;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          if (dir_q) begin
            state_nxt = WB;
          end else if (last) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      WB: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = REQ;
          idx_nxt   = idx + 3'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.mem_req     = (state == REQ);
    bus.mem_we      = (state == REQ) && !dir_q;
    bus.mem_addr    = (state == REQ) ? addr_cur : 16'd0;
    bus.mem_wdata   = (state == REQ && !dir_q) ? bus.rf_out : 16'd0;
    bus.rf_readAdd  = idx;
    bus.rf_write    = (state == WB);
    bus.rf_writeAdd = wadd_q;
    bus.rf_in       = rf_in_q;
  end

`ifdef REGXFER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= 16'd0;
    end else if (accept) begin
      csum <= 16'd0;
    end else if (state == REQ && bus.mem_ack) begin
      csum <= csum + (dir_q ? bus.mem_rdata : bus.rf_out);
    end
  end

  assign bus.checksum = csum;
`endif

endmodule

// File: tb/tb_regfile_xfer.sv
// tb/tb_regfile_xfer.sv - self-checking bench for regfile_xfer
module tb_regfile_xfer;
  localparam int NREGS  = 8;
  localparam int STRIDE = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_xfer_if bus();

  regfile_xfer #(.NREGS(NREGS), .STRIDE(STRIDE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rf  [0:7];
  logic [15:0] mem [0:65535];

  int   lat = 0;
  int   wcnt = 0;
  logic ack_en = 1'b1;
  logic stray = 1'b0;

  int   tests = 0;
  int   fails = 0;

  logic        chk_en = 1'b0;
  logic        exp_dir = 1'b0;
  logic [15:0] exp_base = 16'd0;
  int          k = 0;
  logic        pend_wb = 1'b0;
  int          done_cnt = 0;
  logic [15:0] sum = 16'd0;

  assign bus.rf_out    = rf[bus.rf_readAdd];
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ack   = (bus.mem_req && ack_en && (wcnt == lat)) || stray;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] addr_of(input int i);
    return exp_base + 16'(i * STRIDE);
  endfunction

  // Environment: memory latency counter, memory writes, register file writes.
  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.rf_write) rf[bus.rf_writeAdd] <= bus.rf_in;
  end

  // Transaction-level model: the k-th transfer touches register k at base+k*STRIDE.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.mem_req) begin
        if (k >= NREGS) begin
          chk("extra_req", 32'(k), 32'(NREGS - 1));
        end else begin
          chk("mem_addr", bus.mem_addr, addr_of(k));
          chk("mem_we", bus.mem_we, !exp_dir);
          chk("rf_readAdd", bus.rf_readAdd, k);
          if (!exp_dir) chk("mem_wdata", bus.mem_wdata, rf[k]);
          if (bus.mem_ack) begin
            sum = sum + (exp_dir ? mem[addr_of(k)] : rf[k]);
            if (exp_dir) pend_wb = 1'b1;
            else k++;
          end
        end
      end
      if (bus.rf_write) begin
        chk("rf_write_allowed", {exp_dir, pend_wb}, 2'b11);
        chk("rf_writeAdd", bus.rf_writeAdd, k);
        chk("rf_in", bus.rf_in, mem[addr_of(k)]);
        pend_wb = 1'b0;
        k++;
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rf_write"}, bus.rf_write, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_rf_readAdd"}, bus.rf_readAdd, 0);
    chk({tag, "_rf_writeAdd"}, bus.rf_writeAdd, 0);
    chk({tag, "_rf_in"}, bus.rf_in, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  task automatic run(input logic d, input logic [15:0] base, input int latency,
                     input int exp_cyc, input string nm);
    int cyc;
    lat = latency; exp_dir = d; exp_base = base; k = 0; pend_wb = 1'b0;
    sum = 16'd0; done_cnt = 0; chk_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dir = d; bus.base_addr = base;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dir = ~d; bus.base_addr = 16'hDEAD;
    chk({nm, "_busy"}, bus.busy, 1);
    cyc = 2;
    while (!bus.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_cycles"}, cyc, exp_cyc);
    chk({nm, "_count"}, k, NREGS);
`ifdef REGXFER_CHECKSUM_EN
    chk({nm, "_checksum"}, bus.checksum, sum);
`endif
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, bus.done, 0);
    chk({nm, "_busy_fall"}, bus.busy, 0);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk_en = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = 16'd0;
    for (int i = 0; i < 8; i++) rf[i] <= 16'h1111 * 16'(i + 1);
    #1;
    check_reset("rst");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    stray = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_ack_busy", bus.busy, 0);
    chk("stray_ack_req", bus.mem_req, 0);
    stray = 1'b0;

    run(1'b0, 16'h3000, 0, 10, "dump");
    chk("dump_first", mem[16'h3000], 16'h1111);
    chk("dump_last", mem[16'h300E], 16'h8888);
    for (int i = 0; i < NREGS; i++) chk("dump_mem", mem[16'h3000 + 16'(2 * i)], rf[i]);

    for (int i = 0; i < 8; i++) begin
      mem[16'h4000 + 16'(2 * i)] <= 16'hA000 + 16'(i);
      rf[i] <= 16'h0000;
    end
    #1;
    run(1'b1, 16'h4000, 0, 18, "load");
    chk("load_r0", rf[0], 16'hA000);
    chk("load_r7", rf[7], 16'hA007);
    for (int i = 0; i < NREGS; i++) chk("load_rf", rf[i], mem[16'h4000 + 16'(2 * i)]);

    for (int i = 0; i < 8; i++) rf[i] <= 16'h1111 * 16'(i + 1);
    #1;
    run(1'b0, 16'h3100, 2, 26, "dump_lat");
    chk("dump_lat_r1", mem[16'h3102], 16'h2222);

    run(1'b0, 16'hFFFC, 0, 10, "wrap");
    chk("wrap_fffc", mem[16'hFFFC], 16'h1111);
    chk("wrap_0000", mem[16'h0000], 16'h3333);
    chk("wrap_000a", mem[16'h000A], 16'h8888);

    for (int i = 0; i < 8; i++) begin
      mem[16'h5000 + 16'(2 * i)] <= 16'hB000 + 16'(i);
      rf[i] <= 16'h5555;
    end
    #1;
    lat = 0; exp_dir = 1'b1; exp_base = 16'h5000; k = 0; pend_wb = 1'b0;
    done_cnt = 0; chk_en = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dir = 1'b1; bus.base_addr = 16'h5000;
    @(posedge clk); #1;
    bus.dir = 1'b0; bus.base_addr = 16'h7000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_ignore_start", bus.busy, 1);
    n = 0;
    while (!(bus.rf_write && bus.rf_writeAdd == 3'd2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_wb2", n < 100, 1);
    #2 reset = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("abort_rf_write_async", bus.rf_write, 0);
    check_reset("abort");
    @(posedge clk); #1;
    chk("abort_r0", rf[0], 16'hB000);
    chk("abort_r1", rf[1], 16'hB001);
    chk("abort_r2_kept", rf[2], 16'h5555);
    chk("abort_no_done", done_cnt, 0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_busy", bus.busy, 0);
    chk("abort_idle_done", bus.done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
